// File: rtl/ipm_red_unmask.sv
// Recovers S from a v-share IPM-RED encoding one share per cycle and checks T == S^3.
// Result is held in DONE until the consumer takes it. A mismatch gives fault=1 and S=0x00.
module ipm_red_unmask #(
  parameter int V = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [V*8-1:0] R,
  input  logic [V*8-1:0] L1,
  input  logic [V*8-1:0] L2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     S,
  output logic           fault
);

  localparam int IW = $clog2(V);

  typedef enum logic [1:0] {IDLE, ACC, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    r_q  [V];
  logic [7:0]    r_d  [V];
  logic [7:0]    l1_q [V];
  logic [7:0]    l1_d [V];
  logic [7:0]    l2_q [V];
  logic [7:0]    l2_d [V];
  logic [7:0]    acc1_q, acc1_d;
  logic [7:0]    acc2_q, acc2_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    s_q, s_d;
  logic          fault_q, fault_d;
  logic          out_valid_q, out_valid_d;
  logic          ok;

  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] cube8(input logic [7:0] a);
    return gmul8(gmul8(a, a), a);
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign fault     = fault_q;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    l1_d        = l1_q;
    l2_d        = l2_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    idx_d       = idx_q;
    s_d         = s_q;
    fault_d     = fault_q;
    out_valid_d = out_valid_q;
    ok          = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < V; j++) begin
            r_d[j]  = R[j*8 +: 8];
            l1_d[j] = L1[j*8 +: 8];
            l2_d[j] = L2[j*8 +: 8];
          end
          acc1_d  = R[7:0];
          acc2_d  = R[15:8];
          idx_d   = IW'(2);
          state_d = ACC;
        end
      end
      ACC: begin
        acc1_d = acc1_q ^ gmul8(l1_q[idx_q], r_q[idx_q]);
        acc2_d = acc2_q ^ gmul8(l2_q[idx_q], r_q[idx_q]);
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(V-1)) state_d = CHECK;
      end
      CHECK: begin
        ok      = (cube8(acc1_q) == acc2_q);
        s_d     = ok ? acc1_q : 8'h00;
        fault_d = !ok;
        state_d = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        // Handshake wipes every register that ever saw share or secret material.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          s_d         = 8'h00;
          fault_d     = 1'b0;
          acc1_d      = 8'h00;
          acc2_d      = 8'h00;
          idx_d       = '0;
          for (int j = 0; j < V; j++) begin
            r_d[j]  = 8'h00;
            l1_d[j] = 8'h00;
            l2_d[j] = 8'h00;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc1_q      <= 8'h00;
      acc2_q      <= 8'h00;
      idx_q       <= '0;
      s_q         <= 8'h00;
      fault_q     <= 1'b0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < V; j++) begin
        r_q[j]  <= 8'h00;
        l1_q[j] <= 8'h00;
        l2_q[j] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      fault_q     <= fault_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
    end
  end

endmodule

// File: tb/tb_ipm_red_unmask.sv
// Scoreboard bench for ipm_red_unmask with a v=3 and a v=4 instance on a shared clock/reset.
module tb_ipm_red_unmask;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_fault;
  logic [23:0] a_R, a_L1, a_L2;
  logic [7:0]  a_S;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fault;
  logic [31:0] b_R, b_L1, b_L2;
  logic [7:0]  b_S;

  ipm_red_unmask #(.V(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .R(a_R), .L1(a_L1), .L2(a_L2), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .S(a_S), .fault(a_fault)
  );

  ipm_red_unmask #(.V(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .R(b_R), .L1(b_L1), .L2(b_L2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .S(b_S), .fault(b_fault)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int acc_a = 0;
  int acc_b = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference multiply: full carry-less product, then polynomial reduction by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_cube(input logic [7:0] a);
    return ref_mul(ref_mul(a, a), a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic send_a(input logic [23:0] r, input logic [23:0] l1, input logic [23:0] l2);
    int n;
    logic [7:0] s, t;
    logic ok;
    a_R = r; a_L1 = l1; a_L2 = l2; a_in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 50) begin step(); n++; end
    total_cnt++;
    if (n >= 50) $display("FAIL send_a_timeout: in_ready never rose");
    else pass_cnt++;
    step();
    a_in_valid = 1'b0;
    acc_a = cyc;
    s  = r[7:0]  ^ ref_mul(l1[23:16], r[23:16]);
    t  = r[15:8] ^ ref_mul(l2[23:16], r[23:16]);
    ok = (ref_cube(s) == t);
    exp_a.push_back({!ok, ok ? s : 8'h00});
  endtask

  task automatic get_a(input string name, output int lat);
    int n;
    logic [8:0] e;
    n = 0;
    lat = -1;
    while (!a_out_valid && n < 50) begin step(); n++; end
    total_cnt++;
    if (n >= 50 || exp_a.size() == 0) begin
      $display("FAIL %s: no result (timeout=%0d queue=%0d)", name, n >= 50, exp_a.size());
    end else begin
      lat = cyc - acc_a;
      e = exp_a.pop_front();
      if ({a_fault, a_S} !== e)
        $display("FAIL %s: got fault=%0b S=0x%02h expected fault=%0b S=0x%02h",
                 name, a_fault, a_S, e[8], e[7:0]);
      else pass_cnt++;
    end
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] r, input logic [31:0] l1, input logic [31:0] l2,
                        input logic [8:0] e);
    int n;
    b_R = r; b_L1 = l1; b_L2 = l2; b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 50) begin step(); n++; end
    total_cnt++;
    if (n >= 50) $display("FAIL send_b_timeout: in_ready never rose");
    else pass_cnt++;
    step();
    b_in_valid = 1'b0;
    acc_b = cyc;
    exp_b.push_back(e);
  endtask

  task automatic get_b(input string name);
    int n;
    logic [8:0] e;
    n = 0;
    while (!b_out_valid && n < 50) begin step(); n++; end
    total_cnt++;
    if (n >= 50 || exp_b.size() == 0) begin
      $display("FAIL %s: no result (timeout=%0d queue=%0d)", name, n >= 50, exp_b.size());
    end else begin
      e = exp_b.pop_front();
      if ({b_fault, b_S} !== e)
        $display("FAIL %s: got fault=%0b S=0x%02h expected fault=%0b S=0x%02h",
                 name, b_fault, b_S, e[8], e[7:0]);
      else pass_cnt++;
    end
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
  endtask

  // Builds a fresh v=4 encoding of s with random masks and public vectors.
  task automatic make_b(input logic [7:0] s, output logic [31:0] r, output logic [31:0] l1,
                        output logic [31:0] l2);
    logic [7:0] r2, r3;
    r2 = 8'($urandom); r3 = 8'($urandom);
    l1 = {8'($urandom), 8'($urandom), 16'h0};
    l2 = {8'($urandom), 8'($urandom), 16'h0};
    r = {r3, r2,
         ref_cube(s) ^ ref_mul(l2[23:16], r2) ^ ref_mul(l2[31:24], r3),
         s ^ ref_mul(l1[23:16], r2) ^ ref_mul(l1[31:24], r3)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_in_ready", 32'(a_in_ready), 32'd1);
    chk("reset_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_S", 32'(a_S), 32'h00);
    chk("reset_fault", 32'(a_fault), 32'd0);
    chk("reset_b_outputs", {b_in_ready, b_out_valid, b_fault, b_S}, {3'b100, 8'h00});
  endtask

  task automatic test_latency();
    int lat;
    send_a({8'h00, 8'h0F, 8'h03}, 24'h010000, 24'h010000);
    get_a("basic_S3", lat);
    chk("basic_latency", 32'(lat), 32'd3);
    chk("basic_in_ready_after_hs", 32'(a_in_ready), 32'd1);
    chk("basic_out_valid_after_hs", 32'(a_out_valid), 32'd0);
  endtask

  task automatic test_masked();
    int lat;
    send_a({8'hAA, 8'hA5, 8'hA9}, 24'h010000, 24'h010000);
    get_a("masked_S3", lat);
    send_a({8'hAA, 8'hA4, 8'hA9}, 24'h010000, 24'h010000);
    get_a("bitflip_fault", lat);
    chk("bitflip_released", 32'(a_out_valid), 32'd0);
  endtask

  task automatic test_zero_one();
    int lat;
    send_a({8'h00, 8'h00, 8'h00}, 24'h010000, 24'h010000);
    get_a("zero_S", lat);
    send_a({8'h00, 8'h01, 8'h01}, 24'h010000, 24'h010000);
    get_a("one_S", lat);
  endtask

  task automatic test_back_to_back();
    int n, lat, hs_cyc;
    logic [7:0] s0;
    logic f0;
    send_a({8'h5C, 8'h0F ^ ref_mul(8'h37, 8'h5C), 8'h03 ^ ref_mul(8'h21, 8'h5C)},
           {8'h21, 16'h0}, {8'h37, 16'h0});
    n = 0;
    while (!a_out_valid && n < 50) begin step(); n++; end
    chk("stall_result_arrives", 32'(n < 50), 32'd1);
    s0 = a_S; f0 = a_fault;
    chk("stall_first_result", {f0, s0}, 32'(exp_a[0]));
    a_R = {8'h00, 8'h01, 8'h01}; a_L1 = 24'h010000; a_L2 = 24'h010000;
    a_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_hold", {a_out_valid, a_in_ready, a_fault, a_S}, {2'b10, f0, s0});
    end
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    hs_cyc = cyc;
    void'(exp_a.pop_front());
    chk("stall_in_ready_after_hs", 32'(a_in_ready), 32'd1);
    send_a({8'h00, 8'h01, 8'h01}, 24'h010000, 24'h010000);
    chk("stall_second_accept_cycle", 32'(acc_a - hs_cyc), 32'd1);
    get_a("stall_second_result", lat);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r, l1, l2;
    logic [7:0] s;
    int seen;
    make_b(8'($urandom), r, l1, l2);
    send_b(r, l1, l2, 9'h000);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_b.delete();
    chk("midrst_outputs", {b_in_ready, b_out_valid, b_fault, b_S}, {3'b100, 8'h00});
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (b_out_valid) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);
    for (int k = 0; k < 4; k++) begin
      s = 8'($urandom);
      make_b(s, r, l1, l2);
      send_b(r, l1, l2, {1'b0, s});
      get_b("v4_random");
    end
    make_b(8'h77, r, l1, l2);
    r[15:8] = r[15:8] ^ 8'h10;
    send_b(r, l1, l2, {1'b1, 8'h00});
    get_b("v4_fault");
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_R = '0; a_L1 = '0; a_L2 = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_R = '0; b_L1 = '0; b_L2 = '0;
    test_reset();
    test_latency();
    test_masked();
    test_zero_one();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
